// File: rtl/apb_pkg.sv
// Shared types and default bus widths for the APB round-robin scheduler.
package apb_pkg;

    localparam int unsigned APB_ADDR_WIDTH = 8;
    localparam int unsigned APB_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

endpackage

// File: rtl/apb_rr_scheduler_if.sv
// APB bus between the scheduler (master) and the completer (slave).
interface apb_rr_scheduler_if #(
    parameter int unsigned ADDR_WIDTH = apb_pkg::APB_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = apb_pkg::APB_DATA_WIDTH
);

    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY
    );

endinterface

// File: rtl/apb_rr_pick.sv
// Round-robin picker: first set request at or above ptr, wrapping at NUM_REQ.
module apb_rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] win_oh_c_o,
    output logic [IDX_W-1:0]   win_idx_c_o,
    output logic               win_vld_c_o
);

    always_comb begin
        win_oh_c_o  = '0;
        win_idx_c_o = '0;
        win_vld_c_o = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            int unsigned j;
            j = (32'(ptr_i) + k) % NUM_REQ;
            if (!win_vld_c_o && req_i[IDX_W'(j)]) begin
                win_vld_c_o             = 1'b1;
                win_idx_c_o             = IDX_W'(j);
                win_oh_c_o[IDX_W'(j)]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_rr_scheduler.sv
// Round-robin arbiter feeding single APB transfers from NUM_REQ requesters,
// with a PREADY timeout that aborts a stalled transfer and flags err.
module apb_rr_scheduler
    import apb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_WIDTH = APB_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = APB_DATA_WIDTH,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                            PCLK,
    input  logic                            PRESETn,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ-1:0]              req_rw,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]              gnt,
    output logic [NUM_REQ-1:0]              done,
    output logic [DATA_WIDTH-1:0]           rdata,
    output logic                            err,
    output logic                            busy,
    apb_rr_scheduler_if.master              apb
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d, idx_q, idx_d;
    logic                   rw_q, rw_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d, rdata_q, rdata_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_REQ-1:0]     gnt_q, gnt_d, done_q, done_d;
    logic                   err_q, err_d, busy_q, busy_d;
    logic                   psel_q, psel_d, penable_q, penable_d;

    logic [NUM_REQ-1:0]     pick_oh_c;
    logic [IDX_W-1:0]       pick_idx_c;
    logic                   pick_vld_c;
    logic                   timeout_c;

    apb_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_i       (req),
        .ptr_i       (ptr_q),
        .win_oh_c_o  (pick_oh_c),
        .win_idx_c_o (pick_idx_c),
        .win_vld_c_o (pick_vld_c)
    );

    // State and datapath registers
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            idx_q     <= '0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
        end
    end

    // Next state; the winner's request fields are captured only on the grant edge
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        cnt_d     = cnt_q;
        timeout_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_vld_c) begin
                    state_d = SETUP;
                    ptr_d   = IDX_W'((32'(pick_idx_c) + 32'd1) % NUM_REQ);
                    idx_d   = pick_idx_c;
                    cnt_d   = '0;
                    for (int unsigned i = 0; i < NUM_REQ; i++) begin
                        if (pick_idx_c == IDX_W'(i)) begin
                            rw_d    = req_rw[i];
                            addr_d  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                            wdata_d = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                        end
                    end
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (apb.PREADY) begin
                    state_d = IDLE;
                    if (!rw_q) begin
                        rdata_d = apb.PRDATA;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        state_d   = IDLE;
                        timeout_c = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode, registered so pulses line up with the state they describe
    always_comb begin
        gnt_d     = '0;
        done_d    = '0;
        err_d     = 1'b0;
        busy_d    = (state_d != IDLE);
        psel_d    = (state_d != IDLE);
        penable_d = (state_d == ACCESS);
        if (state_q == IDLE && state_d == SETUP) begin
            gnt_d = pick_oh_c;
        end
        if (state_q == ACCESS && state_d == IDLE) begin
            done_d = NUM_REQ'(1) << idx_q;
            err_d  = timeout_c;
        end
    end

    assign gnt         = gnt_q;
    assign done        = done_q;
    assign err         = err_q;
    assign busy        = busy_q;
    assign rdata       = rdata_q;
    assign apb.PSEL    = psel_q;
    assign apb.PENABLE = penable_q;
    assign apb.PWRITE  = rw_q;
    assign apb.PADDR   = addr_q;
    assign apb.PWDATA  = wdata_q;

endmodule

// File: tb/tb_apb_rr_scheduler.sv
// Bench for apb_rr_scheduler: vector table plus directed contention and reset
// sequences, checked against grant/completion scoreboard queues.
module tb_apb_rr_scheduler;

    localparam int unsigned NR = 4;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;
    localparam int          TO = 16;

    typedef struct {
        int          idx;
        bit          rw;
        logic [7:0]  addr;
        logic [31:0] wdata;
    } gexp_t;

    typedef struct {
        int          idx;
        bit          err;
        logic [31:0] rdata;
        int          acc;
    } dexp_t;

    typedef struct {
        int          idx;
        bit          rw;
        logic [7:0]  addr;
        logic [31:0] wdata;
        int          waitc;
        bit          err;
        logic [31:0] rdata;
        bit          churn;
    } vec_t;

    logic                PCLK;
    logic                PRESETn;
    logic [NR-1:0]       req;
    logic [NR-1:0]       req_rw;
    logic [NR*AW-1:0]    req_addr;
    logic [NR*DW-1:0]    req_wdata;
    logic [NR-1:0]       gnt;
    logic [NR-1:0]       done;
    logic [DW-1:0]       rdata;
    logic                err;
    logic                busy;

    apb_rr_scheduler_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb_rr_scheduler #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)
    ) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req(req), .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
        .gnt(gnt), .done(done), .rdata(rdata), .err(err), .busy(busy),
        .apb(bus)
    );

    int    checks   = 0;
    int    failures = 0;
    int    slv_wait = 0;
    gexp_t exp_gnt[$];
    dexp_t exp_done[$];
    vec_t  vecs[8];

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Completer model: PREADY after slv_wait low ACCESS cycles, garbage PRDATA while waiting
    initial begin : slave
        logic [31:0] mem [256];
        int cnt;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        cnt        = 0;
        bus.PREADY = 1'b0;
        bus.PRDATA = '0;
        forever begin
            @(negedge PCLK);
            if (bus.PSEL && bus.PENABLE) begin
                if (cnt >= slv_wait) begin
                    bus.PREADY = 1'b1;
                    if (bus.PWRITE) mem[bus.PADDR] = bus.PWDATA;
                    bus.PRDATA = mem[bus.PADDR];
                end else begin
                    bus.PREADY = 1'b0;
                    bus.PRDATA = $urandom();
                end
                cnt++;
            end else begin
                bus.PREADY = 1'b0;
                cnt        = 0;
            end
        end
    end

    // Monitor: pops scoreboard entries on gnt/done and checks the bus while in flight
    initial begin : monitor
        gexp_t cur;
        dexp_t d;
        int    acc_n;
        cur   = '{0, 1'b0, 8'h0, 32'h0};
        acc_n = 0;
        forever begin
            @(negedge PCLK);
            if (PRESETn) begin
                if (bus.PSEL && bus.PENABLE) begin
                    acc_n++;
                    check("access_paddr",  64'(bus.PADDR),  64'(cur.addr));
                    check("access_pwrite", 64'(bus.PWRITE), 64'(cur.rw));
                    check("access_pwdata", 64'(bus.PWDATA), 64'(cur.wdata));
                end
                if (gnt != '0) begin
                    check("gnt_expected", 64'(exp_gnt.size() != 0), 64'(1));
                    if (exp_gnt.size() != 0) begin
                        cur   = exp_gnt.pop_front();
                        acc_n = 0;
                        check("gnt_onehot",  64'(gnt), 64'(NR'(1) << cur.idx));
                        check("setup_phase", 64'({bus.PSEL, bus.PENABLE, busy}), 64'(3'b101));
                        check("setup_paddr", 64'(bus.PADDR), 64'(cur.addr));
                        check("setup_pwrite", 64'(bus.PWRITE), 64'(cur.rw));
                    end
                end
                if (done != '0) begin
                    check("done_expected", 64'(exp_done.size() != 0), 64'(1));
                    if (exp_done.size() != 0) begin
                        d = exp_done.pop_front();
                        check("done_onehot", 64'(done),  64'(NR'(1) << d.idx));
                        check("done_err",    64'(err),   64'(d.err));
                        check("done_rdata",  64'(rdata), 64'(d.rdata));
                        check("access_cycles", 64'(acc_n), 64'(d.acc));
                        check("done_idle",   64'({bus.PSEL, bus.PENABLE, busy}), 64'(3'b000));
                    end
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"},     64'(gnt),         64'(0));
        check({tag, "_done"},    64'(done),        64'(0));
        check({tag, "_err"},     64'(err),         64'(0));
        check({tag, "_busy"},    64'(busy),        64'(0));
        check({tag, "_psel"},    64'(bus.PSEL),    64'(0));
        check({tag, "_penable"}, 64'(bus.PENABLE), 64'(0));
        check({tag, "_pwrite"},  64'(bus.PWRITE),  64'(0));
        check({tag, "_paddr"},   64'(bus.PADDR),   64'(0));
        check({tag, "_pwdata"},  64'(bus.PWDATA),  64'(0));
        check({tag, "_rdata"},   64'(rdata),       64'(0));
    endtask

    task automatic set_slot(input int i, input bit rw, input logic [7:0] a, input logic [31:0] w);
        req_rw[i]              = rw;
        req_addr[i*AW +: AW]   = a;
        req_wdata[i*DW +: DW]  = w;
    endtask

    task automatic wait_gnt(output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge PCLK);
            n++;
            if (gnt != '0) begin
                ok = 1'b1;
                break;
            end
        end
        check("gnt_seen", 64'(ok), 64'(1));
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge PCLK);
            if (done != '0) begin
                ok = 1'b1;
                break;
            end
        end
        check("done_seen", 64'(ok), 64'(1));
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 50; i++) begin
            @(negedge PCLK);
            if (!busy) break;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        bit ok;
        wait_idle();
        set_slot(v.idx, v.rw, v.addr, v.wdata);
        slv_wait = v.waitc;
        exp_gnt.push_back('{v.idx, v.rw, v.addr, v.wdata});
        exp_done.push_back('{v.idx, v.err, v.rdata, v.err ? TO : v.waitc + 1});
        req[v.idx] = 1'b1;
        wait_gnt(n, ok);
        req = '0;
        if (v.churn) set_slot(v.idx, ~v.rw, 8'h55, ~v.wdata);
        wait_done();
    endtask

    initial begin : main
        int n;
        bit ok;
        vecs[0] = '{0, 1'b1, 8'h10, 32'hDEADBEEF,  1, 1'b0, 32'h0000_0000, 1'b1};
        vecs[1] = '{2, 1'b0, 8'h10, 32'h0,         1, 1'b0, 32'hDEADBEEF,  1'b0};
        vecs[2] = '{1, 1'b1, 8'h20, 32'h12345678,  0, 1'b0, 32'hDEADBEEF,  1'b0};
        vecs[3] = '{3, 1'b0, 8'h20, 32'h0,         3, 1'b0, 32'h12345678,  1'b1};
        vecs[4] = '{1, 1'b0, 8'h30, 32'h0,         0, 1'b0, 32'h0000_0000, 1'b0};
        vecs[5] = '{2, 1'b1, 8'h40, 32'hA5A5A5A5,  2, 1'b0, 32'h0000_0000, 1'b0};
        vecs[6] = '{0, 1'b0, 8'h40, 32'h0,        15, 1'b0, 32'hA5A5A5A5,  1'b0};
        vecs[7] = '{3, 1'b0, 8'h10, 32'h0,        16, 1'b1, 32'hA5A5A5A5,  1'b0};

        PRESETn   = 1'b0;
        req       = '0;
        req_rw    = '0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (3) @(negedge PCLK);
        check_all_zero("reset");
        PRESETn = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Contention from a fresh reset: ptr starts at 0, grants rotate 0,1,2,3,0
        wait_idle();
        PRESETn = 1'b0;
        @(negedge PCLK);
        PRESETn = 1'b1;
        for (int i = 0; i < 4; i++) set_slot(i, 1'b1, 8'h80 + 8'(i), 32'hC0DE0000 + 32'(i));
        slv_wait = 0;
        for (int k = 0; k < 5; k++) begin
            exp_gnt.push_back('{k % 4, 1'b1, 8'h80 + 8'(k % 4), 32'hC0DE0000 + 32'(k % 4)});
            exp_done.push_back('{k % 4, 1'b0, 32'h0, 1});
        end
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_gnt(n, ok);
            if (k > 0) check("gnt_spacing", 64'(n), 64'(3));
        end
        req = '0;
        wait_done();

        // Reset during ACCESS: no done for the aborted transfer, pointer back to 0
        wait_idle();
        set_slot(1, 1'b0, 8'h10, 32'h0);
        slv_wait = 1000;
        exp_gnt.push_back('{1, 1'b0, 8'h10, 32'h0});
        req = 4'b0010;
        wait_gnt(n, ok);
        req = '0;
        repeat (2) @(negedge PCLK);
        #2 PRESETn = 1'b0;
        #1 check_all_zero("midreset");
        set_slot(0, 1'b1, 8'h60, 32'h0BADF00D);
        set_slot(3, 1'b1, 8'h70, 32'h11111111);
        req      = 4'b1011;
        slv_wait = 0;
        exp_gnt.push_back('{0, 1'b1, 8'h60, 32'h0BADF00D});
        exp_done.push_back('{0, 1'b0, 32'h0, 1});
        repeat (3) @(negedge PCLK);
        PRESETn = 1'b1;
        wait_gnt(n, ok);
        req = '0;
        wait_done();
        repeat (4) @(negedge PCLK);

        check("gnt_queue_empty",  64'(exp_gnt.size()),  64'(0));
        check("done_queue_empty", 64'(exp_done.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_rr_scheduler.md
APB_RR_SCHEDULER -- requirements
Module: apb_rr_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, APB address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, APB data width.
REQ-004 SHALL have parameter TIMEOUT, default 16, maximum ACCESS cycles waiting for PREADY.
REQ-005 SHALL use one clock and an asynchronous active-low reset, with ports as follows.
- PCLK  in  1  clock; all logic on rising edge.
- PRESETn  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester transfer request, level.
- req_rw  in  NUM_REQ  per-requester direction, 1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses; slice i belongs to requester i.
- req_wdata  in  NUM_REQ*DATA_WIDTH  flattened write data.
- gnt  out  NUM_REQ  one-hot, one-cycle grant pulse.
- done  out  NUM_REQ  one-hot, one-cycle completion pulse.
- rdata  out  DATA_WIDTH  read data of the last completed read.
- err  out  1  high together with done when the transfer timed out.
- busy  out  1  high in SETUP or ACCESS.
- PSEL, PENABLE, PWRITE  out  1 each  APB control.
- PADDR  out  ADDR_WIDTH  APB address.
- PWDATA  out  DATA_WIDTH  APB write data.
- PRDATA  in  DATA_WIDTH  APB read data.
- PREADY  in  1  APB ready.

Function
REQ-006 SHALL implement the FSM states IDLE, SETUP and ACCESS.
REQ-007 In IDLE with any req bit high, SHALL select the first set req bit, searching upward from ptr with wrap at NUM_REQ, and then on the edge:
- latch the winner's index, rw, addr and wdata;
- go to SETUP;
- set ptr to (winner+1) mod NUM_REQ.
REQ-008 In IDLE with no req bit high, SHALL stay in IDLE and SHALL leave ptr unchanged.
REQ-009 SHALL assert gnt[idx] only during the SETUP cycle; the requester may drop req from the next cycle onward.
REQ-010 SETUP SHALL drive PSEL=1 and PENABLE=0, and SHALL always go to ACCESS after one cycle.
REQ-011 ACCESS SHALL drive PSEL=1 and PENABLE=1, and SHALL stay in ACCESS while PREADY=0 and the timeout count is below TIMEOUT.
REQ-012 In ACCESS with PREADY=1, SHALL capture PRDATA into rdata if the transfer is a read (otherwise rdata holds), and SHALL go to IDLE.
REQ-013 SHALL pulse done[idx] with err=0 in the cycle after the PREADY handshake, i.e. in the first IDLE cycle.
REQ-014 SHALL count ACCESS cycles with PREADY=0, clearing the count on entry to SETUP.
REQ-015 When the count reaches TIMEOUT, SHALL abort to IDLE, SHALL leave rdata unchanged, and SHALL pulse done[idx] with err=1 on the next cycle.
REQ-016 PWRITE, PADDR and PWDATA SHALL come from the latched registers, stable from SETUP through ACCESS, and SHALL hold their last values in IDLE.
REQ-017 PSEL and PENABLE SHALL be decoded from state only; PENABLE is never high without PSEL.
REQ-018 Changes on req, req_rw, req_addr or req_wdata after the grant edge SHALL NOT affect the transfer in flight.
REQ-019 Always returning to IDLE SHALL give a minimum of 3 cycles per transfer (SETUP, ACCESS, IDLE); requests arriving while busy SHALL wait.
REQ-020 A request held high with no other requester SHALL be re-granted every 3 cycles when PREADY is tied high.

Reset
REQ-021 On PRESETn low, asynchronously and regardless of state, SHALL set:
- state to IDLE and ptr to 0;
- the latched index, timeout count and rdata to 0;
- gnt, done, err, busy, PSEL, PENABLE, PWRITE, PADDR and PWDATA to 0.
REQ-022 Reset asserted mid-transfer SHALL abort it with no done pulse; after release the first grant SHALL search from requester 0.

Structure
REQ-023 Package apb_pkg SHALL hold the state_t enum (IDLE, SETUP, ACCESS) and the default ADDR_WIDTH/DATA_WIDTH localparams.
REQ-024 Sub-module apb_rr_pick SHALL take req and ptr and return a one-hot winner plus its index, purely combinationally.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Single write: req[0]=1, rw=1, addr=0x10, wdata=0xDEADBEEF, PREADY high one cycle after PENABLE -> gnt[0] in SETUP, PADDR=0x10 through ACCESS, done[0] with err=0.
- Read-back: req[2], read of addr 0x10 -> rdata=0xDEADBEEF with done[2].
- Contention: req=4'b1111 held, ptr=0 -> grant order 0,1,2,3,0; gnt pulses 3 cycles apart with PREADY tied high.
- Timeout: PREADY stuck 0 -> after 16 ACCESS cycles PSEL drops, done[idx]=1 with err=1, rdata unchanged.
- Reset mid-ACCESS: PRESETn low -> all outputs 0 immediately, no done pulse; next grant goes to the lowest set req bit.
- Input churn: req_addr changed to 0x55 during ACCESS -> PADDR holds the latched value 0x10.
